// File: rtl/demux16b1x8_buf_pkg.sv
// demux16b1x8_buf_pkg: shared sizing constants for the 1-to-8 buffered demux
package demux16b1x8_buf_pkg;
    localparam int DEMUX_CH = 8;
    localparam int DEMUX_AW = 3;
    localparam int DEMUX_DW = 16;
endpackage

// File: rtl/demux16b1x8_buf_slot.sv
// demux16b1x8_buf_slot: one-entry holding register with full flag for one output channel
module demux16b1x8_buf_slot
    import demux16b1x8_buf_pkg::*;
#(
    parameter int DATA_W       = DEMUX_DW,
    parameter bit ALLOW_REFILL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              consume,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              free,
    output logic [DATA_W-1:0] dout
);
    logic              r_full;
    logic [DATA_W-1:0] r_data;

    assign full = r_full;
    assign dout = r_data;
    assign free = ~r_full | (ALLOW_REFILL & consume);

    // load wins over consume so a same-cycle refill keeps the slot full with the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (load) begin
            r_full <= 1'b1;
            r_data <= din;
        end else if (consume) begin
            r_full <= 1'b0;
        end
    end
endmodule

// File: rtl/demux16b1x8_buf.sv
// demux16b1x8_buf: steers or broadcasts a word into eight buffered valid/ready output channels
module demux16b1x8_buf
    import demux16b1x8_buf_pkg::*;
#(
    parameter int DATA_W       = DEMUX_DW,
    parameter bit ALLOW_REFILL = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DEMUX_AW-1:0]        in_addr,
    input  logic                       in_bcast,
    input  logic [DATA_W-1:0]          in_data,
    output logic [DEMUX_CH-1:0]        out_valid,
    input  logic [DEMUX_CH-1:0]        out_ready,
    output logic [DEMUX_CH*DATA_W-1:0] out_data
);
    logic [DEMUX_CH-1:0] w_free;
    logic [DEMUX_CH-1:0] w_onehot;
    logic [DEMUX_CH-1:0] w_load;
    logic                w_accept;

    assign w_onehot = {{(DEMUX_CH-1){1'b0}}, 1'b1} << in_addr;
    assign in_ready = in_bcast ? &w_free : w_free[in_addr];
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_accept ? (in_bcast ? {DEMUX_CH{1'b1}} : w_onehot) : '0;

    for (genvar k = 0; k < DEMUX_CH; k++) begin : g_slot
        demux16b1x8_buf_slot #(
            .DATA_W       (DATA_W),
            .ALLOW_REFILL (ALLOW_REFILL)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (w_load[k]),
            .consume (out_ready[k]),
            .din     (in_data),
            .full    (out_valid[k]),
            .free    (w_free[k]),
            .dout    (out_data[k*DATA_W +: DATA_W])
        );
    end
endmodule
